// File: rtl/scope_readout.sv
// Host-side scope readout: arms a capture, then streams the capture RAM oldest-sample-first
// over a valid/ready byte interface. Optional two-byte header (0xA5, 0x5A) under READOUT_HEADER_EN.
module scope_readout #(
  parameter int ADDR_W = 9,
  parameter int DATA_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              i_arm,
  output logic              o_start,
  output logic              o_stop,
  input  logic              i_busy,
  input  logic              i_done,
  input  logic [ADDR_W-1:0] i_wr_ptr,
  output logic              o_rd_en,
  output logic [ADDR_W-1:0] o_rd_addr,
  input  logic [DATA_W-1:0] i_rd_data,
  output logic [7:0]        o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_last,
  output logic              o_active
);

  // Byte handshake: o_data/o_valid/o_last are registered; a byte moves on a rising edge where
  // o_valid & i_ready, and once o_valid is up o_data stays put until that edge.
  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_ARM  = 3'd1,
    S_WAIT = 3'd2,
    S_RD   = 3'd3,
    S_HOLD = 3'd4,
    S_REL  = 3'd5
`ifdef READOUT_HEADER_EN
    ,
    S_HDR0 = 3'd6,
    S_HDR1 = 3'd7
`endif
  } state_e;

  localparam logic [ADDR_W:0] LAST_IDX = {1'b0, {ADDR_W{1'b1}}};

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] ptr_q, ptr_d;
  logic [ADDR_W:0]   cnt_q, cnt_d;
  logic              fill_q, fill_d;
  logic              start_q, start_d;
  logic              stop_q, stop_d;
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic [7:0]        data_q, data_d;
  logic              valid_q, valid_d;
  logic              last_q, last_d;
  logic              active_q, active_d;
  logic              xfer;

  always_comb begin
    state_d   = state_q;
    ptr_d     = ptr_q;
    cnt_d     = cnt_q;
    fill_d    = 1'b0;
    start_d   = start_q;
    stop_d    = stop_q;
    rd_en_d   = 1'b0;
    rd_addr_d = rd_addr_q;
    data_d    = data_q;
    valid_d   = valid_q;
    last_d    = last_q;
    xfer      = valid_q & i_ready;

    case (state_q)
      S_IDLE: begin
        if (i_arm) begin
          state_d = S_ARM;
          start_d = 1'b1;
        end
      end
      S_ARM: begin
        if (i_busy) begin
          state_d = S_WAIT;
          start_d = 1'b0;
        end
      end
      S_WAIT: begin
        if (i_done) begin
          ptr_d = i_wr_ptr;
          cnt_d = '0;
`ifdef READOUT_HEADER_EN
          state_d = S_HDR0;
          data_d  = 8'hA5;
          valid_d = 1'b1;
          last_d  = 1'b0;
`else
          state_d   = S_RD;
          rd_en_d   = 1'b1;
          rd_addr_d = i_wr_ptr;
`endif
        end
      end
`ifdef READOUT_HEADER_EN
      S_HDR0: begin
        if (xfer) begin
          state_d = S_HDR1;
          data_d  = 8'h5A;
        end
      end
      S_HDR1: begin
        if (xfer) begin
          state_d   = S_RD;
          valid_d   = 1'b0;
          rd_en_d   = 1'b1;
          rd_addr_d = ptr_q;
        end
      end
`endif
      S_RD: begin
        state_d = S_HOLD;
        fill_d  = 1'b1;
      end
      S_HOLD: begin
        // RAM data arrives the cycle after the strobe, so the first HOLD cycle loads it.
        if (fill_q) begin
          data_d  = i_rd_data[7:0];
          valid_d = 1'b1;
          last_d  = (cnt_q == LAST_IDX);
        end else if (xfer) begin
          ptr_d   = ptr_q + 1'b1;
          cnt_d   = cnt_q + 1'b1;
          valid_d = 1'b0;
          last_d  = 1'b0;
          if (cnt_q == LAST_IDX) begin
            state_d = S_REL;
            stop_d  = 1'b1;
          end else begin
            state_d   = S_RD;
            rd_en_d   = 1'b1;
            rd_addr_d = ptr_q + 1'b1;
          end
        end
      end
      S_REL: begin
        if (!i_done) begin
          state_d = S_IDLE;
          stop_d  = 1'b0;
        end
      end
      default: begin
        state_d = S_IDLE;
        start_d = 1'b0;
        stop_d  = 1'b0;
        valid_d = 1'b0;
        last_d  = 1'b0;
      end
    endcase

    active_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= S_IDLE;
      ptr_q     <= '0;
      cnt_q     <= '0;
      fill_q    <= 1'b0;
      start_q   <= 1'b0;
      stop_q    <= 1'b0;
      rd_en_q   <= 1'b0;
      rd_addr_q <= '0;
      data_q    <= '0;
      valid_q   <= 1'b0;
      last_q    <= 1'b0;
      active_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      ptr_q     <= ptr_d;
      cnt_q     <= cnt_d;
      fill_q    <= fill_d;
      start_q   <= start_d;
      stop_q    <= stop_d;
      rd_en_q   <= rd_en_d;
      rd_addr_q <= rd_addr_d;
      data_q    <= data_d;
      valid_q   <= valid_d;
      last_q    <= last_d;
      active_q  <= active_d;
    end
  end

  assign o_start   = start_q;
  assign o_stop    = stop_q;
  assign o_rd_en   = rd_en_q;
  assign o_rd_addr = rd_addr_q;
  assign o_data    = data_q;
  assign o_valid   = valid_q;
  assign o_last    = last_q;
  assign o_active  = active_q;

endmodule
